// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU issue/sequencing logic:
// op codes, sequencer state encoding and the default datapath width.
package alu_ctrl_pkg;

   localparam int DATA_WIDTH_DEF = 32;

   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_iter_mul_dp.sv
// Radix-2 shift-add multiply datapath: one partial-product accumulation
// per step; acc_next_o exposes the accumulator value after the current step.
module iter_mul_dp
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic                  step_i,
   input  logic                  clear_i,
   input  logic [DATA_WIDTH-1:0] mcand_i,
   input  logic [DATA_WIDTH-1:0] mplier_i,
   output logic [DATA_WIDTH-1:0] acc_next_o
);

   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;

   // Low-half product only, so two's-complement operands need no correction.
   always_comb begin
      acc_next_o = acc;
      if (mplier[0])
         acc_next_o = acc + mcand;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (clear_i) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (load_i) begin
         acc    <= '0;
         mcand  <= mcand_i;
         mplier <= mplier_i;
      end else if (step_i) begin
         acc    <= acc_next_o;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: rtl/alu_mul_sequencer.sv
// EX-stage ALU issue controller: single-cycle logic/arith ops plus an
// iterative multiply that stalls the upstream pipeline while it runs.
module alu_mul_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic [2:0]            ALUCtrl_i,
   input  logic [DATA_WIDTH-1:0] data1_i,
   input  logic [DATA_WIDTH-1:0] data2_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  busy_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  result_valid_o
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

   seq_state_t            state;
   seq_state_t            state_next;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_next;
   logic [DATA_WIDTH-1:0] single_res;
   logic [DATA_WIDTH-1:0] acc_next;
   logic                  issue_req;
   logic                  mul_req;
   logic                  single_issue;
   logic                  mul_issue;
   logic                  last_step;
   logic                  dp_load;
   logic                  dp_step;
   logic                  dp_clear;

   assign issue_req    = (state == IDLE) && valid_i;
   assign mul_req      = issue_req && (ALUCtrl_i == OP_MUL);
   assign single_issue = issue_req && (ALUCtrl_i != OP_MUL) && !flush_i;
   assign mul_issue    = mul_req && !flush_i;
   assign last_step    = (state == RUN) && (count == LAST_COUNT);

   assign busy_o  = (state != IDLE);
   assign stall_o = !rst_i && (mul_issue || (state == RUN));

   always_comb begin
      single_res = '0;
      case (ALUCtrl_i)
         OP_AND:  single_res = data1_i & data2_i;
         OP_OR:   single_res = data1_i | data2_i;
         OP_ADD:  single_res = data1_i + data2_i;
         OP_SUB:  single_res = data1_i - data2_i;
         default: single_res = '0;
      endcase
   end

   always_comb begin
      state_next = state;
      count_next = count;
      dp_load    = 1'b0;
      dp_step    = 1'b0;
      dp_clear   = 1'b0;
      if (flush_i) begin
         state_next = IDLE;
         count_next = '0;
         dp_clear   = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (mul_issue) begin
                  state_next = RUN;
                  count_next = '0;
                  dp_load    = 1'b1;
               end
            end
            RUN: begin
               dp_step = 1'b1;
               if (last_step) begin
                  state_next = DONE;
                  count_next = '0;
               end else begin
                  count_next = count + 1'b1;
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // The multiply's final step lands in result_o on entry to DONE, so the
   // pulse there is the registered flag set at that edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_o       <= '0;
         result_valid_o <= 1'b0;
      end else begin
         result_valid_o <= 1'b0;
         if (!flush_i) begin
            if (single_issue) begin
               result_o       <= single_res;
               result_valid_o <= 1'b1;
            end else if (last_step) begin
               result_o       <= acc_next;
               result_valid_o <= 1'b1;
            end
         end
      end
   end

   iter_mul_dp #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_iter_mul_dp (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (dp_load),
      .step_i     (dp_step),
      .clear_i    (dp_clear),
      .mcand_i    (data1_i),
      .mplier_i   (data2_i),
      .acc_next_o (acc_next)
   );

endmodule
